// File: rtl/dqn_fixed_pkg.sv
// Shared fixed-point helpers for the DQN dense layer datapath.
// State encoding, accumulator sizing and saturation.
package dqn_fixed_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic int acc_width(
    input int num_in,
    input int data_width
  );
    return 2 * data_width + $clog2(num_in + 1);
  endfunction

  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int                 dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dense_layer_engine_if.sv
// Start/done handshake plus input, weight and output RAM ports
// of one dense layer engine instance.
interface dense_layer_engine_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 1,
  parameter int ADDR_WIDTH = 5
);
  logic                          i_valid;
  logic                          i_linear;
  logic                          o_busy;
  logic [ADDR_WIDTH-1:0]         o_in_addr;
  logic [DATA_WIDTH-1:0]         i_in_data;
  logic [ADDR_WIDTH-1:0]         o_w_addr;
  logic [LANES*DATA_WIDTH-1:0]   i_w_data;
  logic                          o_out_we;
  logic [ADDR_WIDTH-1:0]         o_out_addr;
  logic [LANES*DATA_WIDTH-1:0]   o_out_data;
  logic                          o_valid;

  modport master (
    input  i_valid, i_linear, i_in_data, i_w_data,
    output o_busy, o_in_addr, o_w_addr, o_out_we,
    output o_out_addr, o_out_data, o_valid
  );

  modport slave (
    output i_valid, i_linear, i_in_data, i_w_data,
    input  o_busy, o_in_addr, o_w_addr, o_out_we,
    input  o_out_addr, o_out_data, o_valid
  );
endinterface

// File: rtl/dense_lane_mac.sv
// One lane: multiply-accumulate, shift, leaky ReLU, saturate.
// DENSE_LAYER_ROUND_EN selects round-half-up instead of floor.
module dense_lane_mac
  import dqn_fixed_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int NUM_IN      = 5,
  parameter int ALPHA_SHIFT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         bias,
  input  logic                         linear,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] w,
  output logic signed [DATA_WIDTH-1:0] y
);
  localparam int AW = acc_width(NUM_IN, DATA_WIDTH);
  localparam logic signed [DATA_WIDTH-1:0] ONE =
    DATA_WIDTH'(1 << FRAC_BITS);

  logic signed [DATA_WIDTH-1:0]   xin;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [AW-1:0]           acc;
  logic signed [AW-1:0]           rnd;
  logic signed [AW-1:0]           shf;
  logic signed [AW-1:0]           lk;

  assign xin  = bias ? ONE : x;
  assign prod = xin * w;

  // accumulator, cleared at the start of every group
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + AW'(prod);
  end

`ifdef DENSE_LAYER_ROUND_EN
  assign rnd = acc + AW'(1 << (FRAC_BITS - 1));
`else
  assign rnd = acc;
`endif

  assign shf = rnd >>> FRAC_BITS;
  assign lk  = (shf[AW-1] && !linear) ?
               (shf >>> ALPHA_SHIFT) : shf;
  assign y   = DATA_WIDTH'(saturate(64'(lk), DATA_WIDTH));

endmodule

// File: rtl/dense_layer_engine.sv
// Dense layer engine: FSM, counters, RAM addressing, lane array.
// Build option DENSE_LAYER_ROUND_EN enables rounding in each lane.
module dense_layer_engine
  import dqn_fixed_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int NUM_IN      = 5,
  parameter int NUM_OUT     = 5,
  parameter int LANES       = 1,
  parameter int ADDR_WIDTH  = 5,
  parameter int ALPHA_SHIFT = 3
) (
  input  logic           clk,
  input  logic           rst,
  dense_layer_engine_if.master bus
);
  localparam int G  = NUM_OUT / LANES;
  localparam int AD = ADDR_WIDTH;

  state_t        state;
  logic [AD-1:0] k;
  logic [AD-1:0] g;
  logic [AD-1:0] wbase;
  logic          lin;
  logic          mac_en;
  logic          mac_bias;
  logic          start;
  logic          last_k;
  logic          last_g;
  logic          clr;

  assign start  = (state == S_IDLE) && bus.i_valid;
  assign last_k = (k == AD'(NUM_IN));
  assign last_g = (g == AD'(G - 1));
  assign clr    = start || (state == S_WRITE);

  // sequencing of fetch, drain and write per group
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      k        <= '0;
      g        <= '0;
      wbase    <= '0;
      lin      <= 1'b0;
      mac_en   <= 1'b0;
      mac_bias <= 1'b0;
    end else begin
      mac_en   <= (state == S_FETCH);
      mac_bias <= (state == S_FETCH) && last_k;
      unique case (state)
        S_IDLE: begin
          if (bus.i_valid) begin
            state <= S_FETCH;
            k     <= '0;
            g     <= '0;
            wbase <= '0;
            lin   <= bus.i_linear;
          end
        end
        S_FETCH: begin
          if (last_k) state <= S_DRAIN;
          else        k     <= k + 1'b1;
        end
        S_DRAIN: state <= S_WRITE;
        S_WRITE: begin
          if (last_g) begin
            state <= S_DONE;
          end else begin
            state <= S_FETCH;
            k     <= '0;
            g     <= g + 1'b1;
            wbase <= wbase + AD'(NUM_IN + 1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy     = (state != S_IDLE);
  assign bus.o_valid    = (state == S_DONE);
  assign bus.o_out_we   = (state == S_WRITE);
  assign bus.o_in_addr  = k;
  assign bus.o_w_addr   = wbase + k;
  assign bus.o_out_addr = g;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] y;

    dense_lane_mac #(
      .DATA_WIDTH  (DATA_WIDTH),
      .FRAC_BITS   (FRAC_BITS),
      .NUM_IN      (NUM_IN),
      .ALPHA_SHIFT (ALPHA_SHIFT)
    ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .en     (mac_en),
      .bias   (mac_bias),
      .linear (lin),
      .x      (bus.i_in_data),
      .w      (bus.i_w_data[l*DATA_WIDTH +: DATA_WIDTH]),
      .y      (y)
    );

    assign bus.o_out_data[l*DATA_WIDTH +: DATA_WIDTH] =
      (state == S_WRITE) ? y : '0;
  end

endmodule

// File: doc/dense_layer_engine.md
# dense_layer_engine

Parametrised fixed-point fully-connected layer engine for the DQN datapath. It is the successor to the fixed 2-5-5-3 float feed-forward: one instance evaluates one dense layer, and a layer sequencer chains instances hidden-1 → hidden-2 → output. Node count, input count, lane parallelism, number format and activation mode (leaky ReLU or linear) are all generic. It reads inputs and weights from external RAMs and writes activations to the next layer's data RAM.

## Interface
- DATA_WIDTH, 16: signed fixed-point word width.
- FRAC_BITS, 8: fractional bits; 1.0 = 2^FRAC_BITS.
- NUM_IN, 5: inputs per node, ≥1.
- NUM_OUT, 5: nodes in this layer; must be a multiple of LANES.
- LANES, 1: nodes computed in parallel.
- ADDR_WIDTH, 5: RAM address width.
- ALPHA_SHIFT, 3: leaky slope = 2^-ALPHA_SHIFT.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  start pulse; sampled only in IDLE.
- i_linear  in  1  1 = no activation (output layer); sampled with i_valid.
- o_busy  out  1  high from the cycle after start through the o_valid cycle.
- o_in_addr  out  ADDR_WIDTH  input-RAM read address.
- i_in_data  in  DATA_WIDTH  input-RAM data, 1-cycle read latency.
- o_w_addr  out  ADDR_WIDTH  weight-RAM read address (banked, one bank per lane).
- i_w_data  in  LANES*DATA_WIDTH  weight words, lane 0 in the LSBs, 1-cycle latency.
- o_out_we  out  1  output write strobe.
- o_out_addr  out  ADDR_WIDTH  output group index g.
- o_out_data  out  LANES*DATA_WIDTH  activations, lane 0 in the LSBs.
- o_valid  out  1  one-cycle layer-done pulse.

## Operation
- FSM states: IDLE → FETCH → DRAIN → WRITE → (FETCH for the next group | DONE) → IDLE.
- Groups: G = NUM_OUT/LANES, indexed g = 0..G-1. Each group stores NUM_IN+1 words per lane. Word k < NUM_IN is a weight; word k = NUM_IN is the bias.
- FETCH runs k = 0..NUM_IN, one per cycle, and drives o_in_addr = k and o_w_addr = g*(NUM_IN+1)+k. The data returns the next cycle.
- Accumulate: acc += x_k*w_k. For the bias term, x is forced to 1.0 and i_in_data is ignored.
- Accumulator width: 2*DATA_WIDTH + clog2(NUM_IN+1), signed. It is cleared on entry to each group.
- WRITE computes per lane:
  - y = acc >>> FRAC_BITS (arithmetic shift, floor).
  - If y < 0 and mode is not linear: y >>>= ALPHA_SHIFT.
  - Saturate y to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Assert o_out_we for one cycle.
- i_valid outside IDLE is ignored. i_linear is latched at start.
- Reset mid-operation: return to IDLE immediately. No further writes, no o_valid.

## Timing
- Reset values: o_busy, o_out_we, o_valid = 0. o_in_addr, o_w_addr, o_out_addr, o_out_data = 0.
- Start edge T:
  - Addresses for k = 0..NUM_IN are driven in cycles T+1..T+NUM_IN+1.
  - DRAIN occupies cycle T+NUM_IN+2.
  - WRITE occupies cycle T+NUM_IN+3.
- Each group takes NUM_IN+3 cycles, with no gap between groups.
- o_valid is high in cycle T + G*(NUM_IN+3) + 1; IDLE follows in the next cycle.
- The earliest accepted restart is the cycle after o_valid.

## Configuration
- DENSE_LAYER_ROUND_EN:
  - Defined: add 2^(FRAC_BITS-1) to acc before the FRAC_BITS shift (round half up).
  - Undefined: truncate (floor).
- The activation and saturation rules are the same in both cases.

## Structure
- Shared package dqn_fixed_pkg holds:
  - the state enum;
  - an acc_width(NUM_IN, DATA_WIDTH) function;
  - a saturate function.
- Sub-module dense_lane_mac holds one lane's multiplier, accumulator, rounding, activation and saturation. It is instantiated LANES times. The top level keeps the FSM, counters and addresses.

## Test plan
- Reset: assert rst mid-idle → all outputs 0, o_busy 0.
- Defaults, inputs 0x0100, weights 0x0080, bias 0x0040, start at T:
  - 5 writes of 0x02C0 to addresses 0..4.
  - o_valid at T+41 only.
- Weights 0xFF00, bias 0, inputs 0x0100:
  - leaky mode → 0xFF60;
  - i_linear = 1 → 0xFB00.
- Saturation:
  - inputs, weights and bias all 0x7FFF → 0x7FFF;
  - weights 0x8000, bias 0x8000, linear → 0x8000.
- Control:
  - i_valid pulsed at T+5 → ignored, o_valid still at T+41;
  - rst at T+10 → no o_out_we, no o_valid;
  - a fresh start afterwards completes normally.
- LANES = 5, inputs 0x0001, weights 0x0080, bias 0:
  - single write at T+8, o_valid at T+9;
  - each lane = 0x0003 with DENSE_LAYER_ROUND_EN, 0x0002 without.
